baud_gen_frac: RTL and testbench

Programmable fractional-N baud tick generator for the UART RX/TX datapaths.
- Produces a single-cycle RX oversample enable and a TX bit enable.
- The divisor is a runtime-writable fixed-point value (integer + fractional part), so the average rate is exact; the divisor is no longer truncated at elaboration.
- RX and TX run as independent tick chains, so the RX phase can be re-aligned on a start-bit edge without disturbing TX.

---
 rtl/baud_gen_frac.sv | 170 +++++++++++++++++
 tb/tb_baud_gen_frac.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_gen_frac
//
// Fractional-N baud tick generator for the UART RX/TX datapaths.
//
// Two independent tick chains (index 0 = RX, index 1 = TX) share one
// runtime-writable fixed-point divisor div_q = {div_int, div_frac}. Each chain
// counts div_int or div_int+1 clocks per period. A fractional accumulator
// chooses which, so the long-run average period is exactly
// div_int + div_frac/2^FRAC_W clocks.
//
// The RX chain tick is the oversample enable. The TX chain tick is divided by
// OSR to form the bit enable. The RX chain can be re-phased on a start-bit
// edge through rx_resync without touching the TX chain.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   enable     tick generation enable; counters hold while low
//   cfg_we     one-cycle divisor write strobe
//   cfg_div    new divisor {div_int[INT_W], div_frac[FRAC_W]}
//   cfg_err    one-cycle pulse after a rejected write (div_int < 2)
//   div_q      current divisor
//   rx_resync  restart RX chain phase
//   rxclk_en   RX oversample tick, one cycle wide
//   txclk_en   TX bit tick, one cycle wide
// ---------------------------------------------------------------------------
module baud_gen_frac #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OSR        = 16,
    parameter int INT_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      cfg_we,
    input  logic [INT_W+FRAC_W-1:0]   cfg_div,
    output logic                      cfg_err,
    output logic [INT_W+FRAC_W-1:0]   div_q,
    input  logic                      rx_resync,
    output logic                      rxclk_en,
    output logic                      txclk_en
);

    localparam int DIV_W = INT_W + FRAC_W;
    localparam int OS_W  = (OSR > 1) ? $clog2(OSR) : 1;

    // Reset divisor: round(CLOCK_FREQ * 2^FRAC_W / (BAUD_RATE * OSR)),
    // evaluated in 64-bit arithmetic so large clock rates cannot overflow.
    localparam longint DEN       = longint'(BAUD_RATE) * longint'(OSR);
    localparam longint NUM       = longint'(CLOCK_FREQ) << FRAC_W;
    localparam longint DEF_DIV_L = (NUM + DEN / 2) / DEN;
    localparam longint DEF_INT_L = DEF_DIV_L >> FRAC_W;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEF_DIV_L);
    localparam logic [INT_W-1:0] DEF_INT = INT_W'(DEF_INT_L);

    generate
        if (DEF_INT_L < 2 || DEF_INT_L >= (longint'(1) << INT_W)) begin : g_bad_def_div
            $error("baud_gen_frac: derived reset divisor integer part must be in 2..2^INT_W-1");
        end
        if (OSR < 4 || OSR > 64) begin : g_bad_osr
            $error("baud_gen_frac: OSR must be in 4..64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_d;
    logic [INT_W-1:0]  cnt_q  [2];
    logic [INT_W-1:0]  cnt_d  [2];
    logic [FRAC_W-1:0] frac_q [2];
    logic [FRAC_W-1:0] frac_d [2];
    logic [OS_W-1:0]   os_cnt_q;
    logic [OS_W-1:0]   os_cnt_d;
    logic              cfg_err_q;
    logic              cfg_err_d;

    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [INT_W-1:0]  new_int;
    logic              wr_ok;
    logic [1:0]        tick;
    logic [FRAC_W:0]   frac_sum [2];

    assign div_int  = div_q[FRAC_W +: INT_W];
    assign div_frac = div_q[FRAC_W-1:0];
    assign new_int  = cfg_div[FRAC_W +: INT_W];
    assign wr_ok    = cfg_we && (new_int >= INT_W'(2));

    // Per-chain tick and fractional accumulator sum. The sum's top bit is the
    // carry that stretches the next period by one clock.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chain
            assign tick[gi]     = enable && (cnt_q[gi] == '0);
            assign frac_sum[gi] = {1'b0, frac_q[gi]} + {1'b0, div_frac};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        div_d     = div_q;
        os_cnt_d  = os_cnt_q;
        cfg_err_d = cfg_we && !wr_ok;

        for (int i = 0; i < 2; i++) begin
            cnt_d[i]  = cnt_q[i];
            frac_d[i] = frac_q[i];

            // A valid write restarts both chains and outranks rx_resync.
            if (wr_ok) begin
                cnt_d[i]  = new_int - INT_W'(1);
                frac_d[i] = '0;
            end else if (i == 0 && rx_resync) begin
                cnt_d[i]  = div_int - INT_W'(1);
                frac_d[i] = '0;
            end else if (tick[i]) begin
                frac_d[i] = frac_sum[i][FRAC_W-1:0];
                cnt_d[i]  = div_int - INT_W'(1) + INT_W'(frac_sum[i][FRAC_W]);
            end else if (enable) begin
                cnt_d[i]  = cnt_q[i] - INT_W'(1);
            end
        end

        if (wr_ok) begin
            div_d    = cfg_div;
            os_cnt_d = '0;
        end else if (tick[1]) begin
            os_cnt_d = (os_cnt_q == OS_W'(OSR - 1)) ? '0 : os_cnt_q + OS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DEF_DIV;
            os_cnt_q  <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= DEF_INT - INT_W'(1);
                frac_q[i] <= '0;
            end
        end else begin
            div_q     <= div_d;
            os_cnt_q  <= os_cnt_d;
            cfg_err_q <= cfg_err_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= cnt_d[i];
                frac_q[i] <= frac_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Ticks are masked in reset, in a valid write cycle, and (RX only) in a
    // resync cycle, because the chain is being reloaded on that edge.
    assign rxclk_en = tick[0] && !rx_resync && !wr_ok && !rst;
    assign txclk_en = tick[1] && (os_cnt_q == OS_W'(OSR - 1)) && !wr_ok && !rst;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// tb_baud_gen_frac
//
// Self-checking bench for baud_gen_frac (default parameters).
//
// Every cycle is compared against a reference model. The model places tick n
// of a chain at enabled-cycle n*div_int + floor((n-1)*div_frac/16), counted
// from the chain's last restart. The bench also runs a table of divisor
// writes, hand-written multi-cycle sequences, and a randomized phase.
// ---------------------------------------------------------------------------
module tb_baud_gen_frac;

    localparam int          OSR     = 16;
    localparam logic [19:0] DEF_DIV = 20'd434;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_we;
    logic [19:0] cfg_div;
    logic        cfg_err;
    logic [19:0] div_q;
    logic        rx_resync;
    logic        rxclk_en;
    logic        txclk_en;

    always #5 clk = ~clk;

    baud_gen_frac dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_we    (cfg_we),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .div_q     (div_q),
        .rx_resync (rx_resync),
        .rxclk_en  (rxclk_en),
        .txclk_en  (txclk_en)
    );

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    bit chk_on = 0;
    int rx_q[$];
    int tx_q[$];

    // Reference model state
    logic [19:0] m_div = DEF_DIV;
    bit          m_err = 0;
    longint      rx_r = 0, rx_j = 1, tx_r = 0, tx_j = 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic bit hit(input longint r, input longint j, input logic [19:0] d);
        longint di;
        longint df;
        di = longint'(d[19:4]);
        df = longint'(d[3:0]);
        return r == j * di + ((j - 1) * df) / 16;
    endfunction

    // One clock cycle: compare outputs with the model, advance the model,
    // then clock the DUT. Pulse inputs are cleared after the edge.
    task automatic cyc();
        bit wr, rx_hit, tx_hit, exp_rx, exp_tx;
        #1;
        wr     = cfg_we && (cfg_div[19:4] >= 16'd2);
        rx_hit = 0;
        tx_hit = 0;
        if (!rst && !wr) begin
            rx_hit = !rx_resync && enable && hit(rx_r + 1, rx_j, m_div);
            tx_hit = enable && hit(tx_r + 1, tx_j, m_div);
        end
        exp_rx = rx_hit;
        exp_tx = tx_hit && (tx_j % OSR == 0);
        if (chk_on) begin
            check("rxclk_en", longint'(rxclk_en), longint'(exp_rx));
            check("txclk_en", longint'(txclk_en), longint'(exp_tx));
            check("cfg_err", longint'(cfg_err), longint'(m_err));
            check("div_q", longint'(div_q), longint'(m_div));
        end
        if (rxclk_en) rx_q.push_back(cyc_n);
        if (txclk_en) tx_q.push_back(cyc_n);
        if (rst) begin
            m_div = DEF_DIV; m_err = 0;
            rx_r = 0; rx_j = 1; tx_r = 0; tx_j = 1;
        end else begin
            m_err = cfg_we && !wr;
            if (wr) begin
                m_div = cfg_div;
                rx_r = 0; rx_j = 1; tx_r = 0; tx_j = 1;
            end else begin
                if (rx_resync) begin
                    rx_r = 0; rx_j = 1;
                end else if (enable) begin
                    rx_r++;
                    if (rx_hit) rx_j++;
                end
                if (enable) begin
                    tx_r++;
                    if (tx_hit) tx_j++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        cfg_we    = 0;
        rx_resync = 0;
    endtask

    task automatic next_tick(input bit is_tx, input int bound, output int t);
        int n0;
        n0 = is_tx ? tx_q.size() : rx_q.size();
        t  = -1;
        for (int i = 0; i < bound; i++) begin
            cyc();
            if (is_tx && tx_q.size() > n0) begin t = tx_q[$]; break; end
            if (!is_tx && rx_q.size() > n0) begin t = rx_q[$]; break; end
        end
        if (t < 0) begin
            tests++;
            fails++;
            $display("FAIL tick_timeout: no %s tick within %0d cycles, required one", is_tx ? "tx" : "rx", bound);
        end
    endtask

    typedef struct {
        logic [19:0] div;
        bit          exp_err;
        logic [19:0] exp_div;
        int          exp_gap;
    } wr_vec_t;

    wr_vec_t vecs [7];

    initial begin
        int tr, tw, t, t2, ta, tb, nrx, ntx;

        vecs[0] = '{div: 20'h00050, exp_err: 0, exp_div: 20'h00050, exp_gap: 5};
        vecs[1] = '{div: 20'h00010, exp_err: 1, exp_div: 20'h00050, exp_gap: 0};
        vecs[2] = '{div: 20'h00020, exp_err: 0, exp_div: 20'h00020, exp_gap: 2};
        vecs[3] = '{div: 20'h00000, exp_err: 1, exp_div: 20'h00020, exp_gap: 0};
        vecs[4] = '{div: 20'h00038, exp_err: 0, exp_div: 20'h00038, exp_gap: 3};
        vecs[5] = '{div: 20'h001B2, exp_err: 0, exp_div: 20'h001B2, exp_gap: 27};
        vecs[6] = '{div: 20'h00050, exp_err: 0, exp_div: 20'h00050, exp_gap: 5};

        rst = 1; enable = 1; cfg_we = 0; cfg_div = '0; rx_resync = 0;
        @(negedge clk);

        // ---- 1: reset state and default rate ----
        cyc();
        chk_on = 1;
        #1;
        check("rst_rxclk_en", longint'(rxclk_en), 0);
        check("rst_txclk_en", longint'(txclk_en), 0);
        check("rst_div_q", longint'(div_q), 434);
        check("rst_cfg_err", longint'(cfg_err), 0);
        cyc();
        tr  = cyc_n - 1;
        rst = 0;
        rx_q.delete();
        tx_q.delete();
        for (int i = 0; i < 6000 && tx_q.size() < 11; i++) cyc();
        check("t1_enough_ticks", longint'(tx_q.size() >= 11 && rx_q.size() >= 161), 1);
        if (tx_q.size() >= 11 && rx_q.size() >= 161) begin
            check("t1_first_rx", rx_q[0] - tr, 27);
            for (int i = 0; i < 8; i++)
                check($sformatf("t1_period_%0d", i + 1), rx_q[i + 1] - rx_q[i], (i == 7) ? 28 : 27);
            check("t1_rx_160_periods", rx_q[160] - rx_q[0], 4340);
            check("t1_tx_10_periods", tx_q[10] - tx_q[0], 4340);
            check("t1_tx_on_16th_rx", tx_q[0], rx_q[15]);
        end

        // ---- divisor write table (items 2 and 3 plus boundaries) ----
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 3; k++) cyc();      // land mid-period
            cfg_we  = 1;
            cfg_div = vecs[v].div;
            cyc();
            tw = cyc_n - 1;
            #1;
            check($sformatf("wr%0d_cfg_err", v), longint'(cfg_err), longint'(vecs[v].exp_err));
            check($sformatf("wr%0d_div_q", v), longint'(div_q), longint'(vecs[v].exp_div));
            if (vecs[v].exp_err) begin
                cyc();
                #1;
                check($sformatf("wr%0d_err_one_cycle", v), longint'(cfg_err), 0);
            end else begin
                next_tick(0, 100, t);
                check($sformatf("wr%0d_first_rx_gap", v), t - tw, vecs[v].exp_gap);
            end
        end

        // ---- 2: TX spacing after writing 0x00050 ----
        cfg_we = 1; cfg_div = 20'h00050;
        cyc();
        tw = cyc_n - 1;
        next_tick(1, 200, ta);
        check("t2_first_tx_gap", ta - tw, 80);
        next_tick(1, 200, tb);
        check("t2_tx_period", tb - ta, 80);
        next_tick(0, 20, t);
        next_tick(0, 20, t2);
        check("t2_rx_period", t2 - t, 5);

        // ---- 4: rx_resync, then write + resync together ----
        next_tick(1, 200, ta);
        next_tick(0, 20, t);
        cyc();
        rx_resync = 1;
        cyc();
        tr = cyc_n - 1;
        next_tick(0, 20, t2);
        check("t4_rx_after_resync", t2 - tr, 5);
        next_tick(1, 200, tb);
        check("t4_tx_spacing", tb - ta, 80);
        for (int k = 0; k < 7; k++) cyc();
        cfg_we = 1; cfg_div = 20'h00050; rx_resync = 1;
        cyc();
        tw = cyc_n - 1;
        next_tick(0, 20, t);
        check("t4_wr_resync_rx", t - tw, 5);
        next_tick(1, 200, tb);
        check("t4_wr_resync_tx", tb - tw, 80);

        // ---- 5: enable gap of 37 cycles ----
        next_tick(0, 20, t);
        cyc();
        cyc();
        enable = 0;
        nrx = rx_q.size();
        ntx = tx_q.size();
        for (int k = 0; k < 37; k++) cyc();
        check("t5_no_rx_in_gap", rx_q.size() - nrx, 0);
        check("t5_no_tx_in_gap", tx_q.size() - ntx, 0);
        enable = 1;
        next_tick(0, 60, t2);
        check("t5_resume", t2 - t, 5 + 37);

        // ---- 6: reset after writing 0x00050 ----
        cfg_we = 1; cfg_div = 20'h00050;
        cyc();
        next_tick(0, 20, t);
        for (int k = 0; k < 4; k++) cyc();
        rst = 1;                                    // this cycle would carry a tick
        #1;
        check("t6_rxclk_in_rst", longint'(rxclk_en), 0);
        cyc();
        tr  = cyc_n - 1;
        rst = 0;
        #1;
        check("t6_div_q", longint'(div_q), 434);
        next_tick(0, 60, t);
        check("t6_first_rx", t - tr, 27);

        // ---- randomized phase against the model ----
        for (int k = 0; k < 4000; k++) begin
            rst       = ($urandom_range(0, 999) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            rx_resync = ($urandom_range(0, 39) == 0);
            cfg_we    = ($urandom_range(0, 149) == 0);
            cfg_div   = {16'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
